// File: rtl/aes_mixcol_seq.sv
// aes_mixcol_seq
// ----------------------------------------------------------------------------
// Column-serial AES MixColumns sequencer. A 128-bit state is accepted over a
// valid/ready handshake. LANES shared single-column GF(2^8) mixers then rewrite
// the working register one group of columns per cycle, and the result is
// handed downstream over a second valid/ready handshake. Bypass returns the
// state unmixed for the final round.
//
// Parameters:
//   LANES      columns mixed per cycle (1, 2 or 4)
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   in_valid   input block valid
//   in_ready   input block accepted on in_valid && in_ready
//   in_state   input state, column c = [127-32c -: 32], FIPS-197 byte order
//   in_bypass  sampled at accept: pass the state through unmixed
//   in_inv     sampled at accept: InvMixColumns (inverse build only)
//   out_valid  out_state holds a finished block
//   out_ready  downstream accepts on out_valid && out_ready
//   out_state  mixed state, same byte order as in_state
//   busy       high while columns are being mixed
//
// Build option:
//   AES_MIXCOL_INV_EN  when defined, every lane also carries an inverse mixer
//                      selected by in_inv; otherwise in_inv is ignored.
// ----------------------------------------------------------------------------
module aes_mixcol_seq #(
  parameter int LANES = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  input  logic         in_bypass,
  input  logic         in_inv,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
      $error("aes_mixcol_seq: LANES must be 1, 2 or 4");
    end
  endgenerate

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Column index of the first column in the final group, and the per-cycle
  // counter step (LANES=4 wraps to 0, the counter never moves in that build).
  localparam logic [1:0] LAST_COL = 2'(4 - LANES);
  localparam logic [1:0] COL_STEP = 2'(LANES);

  logic [1:0]   state_q, state_d;
  logic [127:0] work_q, work_d;
  logic [1:0]   col_cnt_q, col_cnt_d;
  logic         bypass_q, bypass_d;
  logic         accept;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Forward MixColumns of one column, row 0 in the top byte.
  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

`ifdef AES_MIXCOL_INV_EN
  logic inv_q, inv_d;

  // Multiplies by 09, 0b, 0d and 0e are built from the x2/x4/x8 chain.
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] x2, x4, x8;
    logic [31:0] res;
    for (int k = 0; k < 4; k++) begin
      a[k]  = col[31-8*k -: 8];
      x2    = xtime(a[k]);
      x4    = xtime(x2);
      x8    = xtime(x4);
      m9[k] = x8 ^ a[k];
      mb[k] = x8 ^ x2 ^ a[k];
      md[k] = x8 ^ x4 ^ a[k];
      me[k] = x8 ^ x4 ^ x2;
    end
    res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
    return res;
  endfunction

  function automatic logic [31:0] mix_lane(input logic [31:0] col, input logic inv);
    return inv ? mix_inv(col) : mix_fwd(col);
  endfunction
`else
  logic unused_in_inv;
  assign unused_in_inv = in_inv;

  function automatic logic [31:0] mix_lane(input logic [31:0] col);
    return mix_fwd(col);
  endfunction
`endif

  assign accept    = in_valid && in_ready;
  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_BUSY);
  assign out_state = work_q;

  // Next-state logic. DONE shares the IDLE load path so a new block can be
  // taken on the same edge that hands the finished one downstream.
  always_comb begin
    state_d   = state_q;
    work_d    = work_q;
    col_cnt_d = col_cnt_q;
    bypass_d  = bypass_q;
`ifdef AES_MIXCOL_INV_EN
    inv_d     = inv_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          work_d    = in_state;
          bypass_d  = in_bypass;
`ifdef AES_MIXCOL_INV_EN
          inv_d     = in_inv;
`endif
          col_cnt_d = 2'd0;
          state_d   = in_bypass ? ST_DONE : ST_BUSY;
        end else if (state_q == ST_DONE && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // A bypassed block never reaches BUSY; the guard keeps the working
        // register untouched should that ever change.
        if (!bypass_q) begin
          for (int l = 0; l < LANES; l++) begin
`ifdef AES_MIXCOL_INV_EN
            work_d[127-32*(int'(col_cnt_q)+l) -: 32] =
              mix_lane(work_q[127-32*(int'(col_cnt_q)+l) -: 32], inv_q);
`else
            work_d[127-32*(int'(col_cnt_q)+l) -: 32] =
              mix_lane(work_q[127-32*(int'(col_cnt_q)+l) -: 32]);
`endif
          end
        end
        if (col_cnt_q == LAST_COL) begin
          col_cnt_d = 2'd0;
          state_d   = ST_DONE;
        end else begin
          col_cnt_d = col_cnt_q + COL_STEP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset discards any block in flight and wins over accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      work_q    <= '0;
      col_cnt_q <= 2'd0;
      bypass_q  <= 1'b0;
`ifdef AES_MIXCOL_INV_EN
      inv_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      work_q    <= work_d;
      col_cnt_q <= col_cnt_d;
      bypass_q  <= bypass_d;
`ifdef AES_MIXCOL_INV_EN
      inv_q     <= inv_d;
`endif
    end
  end

endmodule
